pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform and recovers the 4-bit duty code.

---
 rtl/pwm_cap_pkg.sv | 22 ++
 rtl/pwm_in_sync.sv | 86 ++++++++
 rtl/pwm_capture.sv | 138 +++++++++++++
 tb/tb_pwm_capture.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared types and helpers for the PWM capture block: FSM state encoding,
// nominal-period and counter-width helpers.
package pwm_cap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } cap_state_e;

  function automatic int nominal_period(input int cnt_w);
    return 1 << cnt_w;
  endfunction

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int CNT_W_DEFAULT  = 4;
  localparam int NOMINAL_PERIOD = nominal_period(CNT_W_DEFAULT);

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch
// filter (PWM_CAP_GLITCH_FILTER_EN), and registered rise/fall strobes.
module pwm_in_sync #(
  parameter int FILT_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  if (FILT_N < 1) begin : g_bad_filt
    $error("pwm_in_sync: FILT_N must be at least 1");
  end

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic s;

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_N + 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] run_q, run_d;

  // The filtered level only flips once the synced input has disagreed with it
  // for FILT_N consecutive cycles; any shorter excursion resets the run.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync_q != filt_q) begin
      if (run_q == FW'(FILT_N - 1)) filt_d = sync_q;
      else                          run_d  = run_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync_q;
`endif

  always_comb begin
    meta_d = pwm_in;
    sync_d = meta_q;
    lvl_d  = s;
    rise_d = s & ~lvl_q;
    fall_d = ~s & lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // lvl is the level delayed to line up with the registered strobes.
  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: recovers the duty code and period of an incoming PWM waveform
// and flags stuck-high / lost input. Optional glitch filter: PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 32,
  parameter int FILT_N  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pwm_in,
  output logic [CNT_W-1:0]              duty_out,
  output logic [cnt_width(TIMEOUT)-1:0] period_out,
  output logic                          duty_valid,
  output logic                          period_ok,
  output logic                          stuck_hi,
  output logic                          sig_lost,
  output cap_state_e                    state_dbg
);

  localparam int              PW      = cnt_width(TIMEOUT);
  localparam logic [PW-1:0]   CNT_MAX = PW'(TIMEOUT);
  localparam logic [PW-1:0]   NOM     = PW'(nominal_period(CNT_W));

  if (TIMEOUT <= nominal_period(CNT_W)) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must exceed 2**CNT_W");
  end

  logic lvl, rise, fall;

  pwm_in_sync #(
    .FILT_N (FILT_N)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  cap_state_e       state_q, state_d;
  logic [PW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [PW-1:0]    hi_len_q, hi_len_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [PW-1:0]    period_q, period_d;
  logic             ok_q, ok_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             lost_q, lost_d;

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    hi_len_d  = hi_len_q;
    duty_d    = duty_q;
    period_d  = period_q;
    ok_d      = ok_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    lost_d    = lost_q;

    if (rise)                     cyc_cnt_d = PW'(1);
    else if (cyc_cnt_q != CNT_MAX) cyc_cnt_d = cyc_cnt_q + PW'(1);

    if (rise)      hi_len_d = PW'(1);
    else if (fall) hi_len_d = cyc_cnt_q;

    case (state_q)
      IDLE: begin
        if (rise) state_d = MEAS;
      end
      MEAS: begin
        // A rise in the same cycle as the timeout still closes a valid period.
        if (rise) begin
          period_d = cyc_cnt_q;
          ok_d     = (cyc_cnt_q == NOM) && (hi_len_q <= NOM);
          if (hi_len_q > NOM)      duty_d = '1;
          else if (hi_len_q == '0) duty_d = '0;
          else                     duty_d = CNT_W'(hi_len_q - PW'(1));
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
          lost_d   = 1'b0;
        end else if (cyc_cnt_q == CNT_MAX) begin
          state_d = STUCK;
          if (lvl) begin
            duty_d   = '1;
            period_d = '0;
            ok_d     = 1'b0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
          end else begin
            lost_d = 1'b1;
          end
        end
      end
      STUCK: begin
        // The period starting here is the first complete one; flags clear when it closes.
        if (rise) state_d = MEAS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      hi_len_q  <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      ok_q      <= 1'b0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      hi_len_q  <= hi_len_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      ok_q      <= ok_d;
      valid_q   <= valid_d;
      stuck_q   <= stuck_d;
      lost_q    <= lost_d;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign duty_valid = valid_q;
  assign period_ok  = ok_q;
  assign stuck_hi   = stuck_q;
  assign sig_lost   = lost_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveform driver with a rise-driven
// expectation model, scoreboard on duty_valid, and per-scenario tasks.
module tb_pwm_capture;
  import pwm_cap_pkg::*;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int FILT_N  = 2;
  localparam int PW      = 6;
  localparam int EW      = 20;
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int LAT = 4 + FILT_N;
`else
  localparam int LAT = 4;
`endif
  localparam int STUCK_LAT = LAT + TIMEOUT;

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] duty_out;
  logic [PW-1:0]    period_out;
  logic             duty_valid;
  logic             period_ok;
  logic             stuck_hi;
  logic             sig_lost;
  cap_state_e       state_dbg;

  pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .FILT_N  (FILT_N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .duty_valid (duty_valid),
    .period_ok  (period_ok),
    .stuck_hi   (stuck_hi),
    .sig_lost   (sig_lost),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int valid_cnt = 0;

  // scoreboard: {lat[7:0], stuck, ok, period[5:0], duty[3:0]}
  logic [EW-1:0] exp_q[$];

  // waveform model state
  logic model_prev, model_meas, model_en;
  int   hi_cnt, len_cnt, rise_cyc;

  task automatic push_raw(input int duty, input int period, input bit ok, input bit stk, input int lat);
    logic [EW-1:0] e;
    e = {8'(lat), stk, ok, 6'(period), 4'(duty)};
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input int hi, input int len, input int lat);
    int d;
    d = (hi - 1 > 15) ? 15 : hi - 1;
    push_raw(d, len, (len == 16) && (hi <= 16), 1'b0, lat);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    if (b && !model_prev) begin
      if (model_en && model_meas) push_exp(hi_cnt, len_cnt, LAT);
      model_meas = 1'b1;
      rise_cyc   = cyc;
      hi_cnt     = 0;
      len_cnt    = 0;
    end
    pwm_in     = b;
    model_prev = b;
    len_cnt++;
    if (b && (hi_cnt == len_cnt - 1)) hi_cnt++;
  endtask

  task automatic send_period(input int hi, input int lo);
    repeat (hi) drive_bit(1'b1);
    repeat (lo) drive_bit(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    pwm_in     = 1'b0;
    model_prev = 1'b0;
    model_meas = 1'b0;
    model_en   = 1'b1;
    hi_cnt     = 0;
    len_cnt    = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && duty_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid duty=%0d period=%0d stuck=%0b", duty_out, period_out, stuck_hi);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (duty_out !== e[3:0]) $display("FAIL sb_duty got=%0d exp=%0d", duty_out, e[3:0]);
        else passes++;
        checks++;
        if (period_out !== e[9:4]) $display("FAIL sb_period got=%0d exp=%0d", period_out, e[9:4]);
        else passes++;
        checks++;
        if (period_ok !== e[10]) $display("FAIL sb_period_ok got=%0b exp=%0b", period_ok, e[10]);
        else passes++;
        checks++;
        if (stuck_hi !== e[11] || sig_lost !== 1'b0)
          $display("FAIL sb_flags got stuck=%0b lost=%0b exp stuck=%0b lost=0", stuck_hi, sig_lost, e[11]);
        else passes++;
        checks++;
        if (cyc - rise_cyc != int'(e[19:12]))
          $display("FAIL sb_latency got=%0d exp=%0d", cyc - rise_cyc, e[19:12]);
        else passes++;
      end
    end
  end

  task automatic check_drained(input string name);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
    else passes++;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({duty_out, period_out, duty_valid, period_ok, stuck_hi, sig_lost} !== '0 || state_dbg !== IDLE)
      $display("FAIL %s got duty=%0d period=%0d v=%0b ok=%0b stk=%0b lost=%0b st=%0d exp all 0/IDLE",
               name, duty_out, period_out, duty_valid, period_ok, stuck_hi, sig_lost, state_dbg);
    else passes++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_idle_outputs("reset_release");
    repeat (5) @(negedge clk);
    check_idle_outputs("reset_quiet");
  endtask

  task automatic test_duty5();
    int v0;
    do_reset();
    v0 = valid_cnt;
    repeat (6) send_period(6, 10);
    check_drained("duty5");
    checks++;
    if (valid_cnt - v0 != 5) $display("FAIL duty5_valid_count got=%0d exp=5", valid_cnt - v0);
    else passes++;
    checks++;
    if (duty_out !== 4'd5 || period_out !== 6'd16 || period_ok !== 1'b1)
      $display("FAIL duty5_hold got duty=%0d period=%0d ok=%0b exp 5/16/1", duty_out, period_out, period_ok);
    else passes++;
  endtask

  task automatic test_duty_patterns();
    int his[$];
    int los[$];
    do_reset();
`ifndef PWM_CAP_GLITCH_FILTER_EN
    his = {1, 1, 15, 15, 8, 8, 20, 3, 3};
    los = {15, 15, 1, 1, 12, 12, 5, 13, 13};
`else
    his = {2, 2, 14, 8, 8, 20, 3, 3};
    los = {14, 14, 2, 12, 12, 5, 13, 13};
`endif
    for (int i = 0; i < his.size(); i++) send_period(his[i], los[i]);
    check_drained("patterns");
    checks++;
    if (duty_out !== 4'd2 || period_out !== 6'd16 || state_dbg !== MEAS)
      $display("FAIL patterns_final got duty=%0d period=%0d st=%0d exp 2/16/MEAS", duty_out, period_out, state_dbg);
    else passes++;
  endtask

  task automatic test_stuck_hi();
    do_reset();
    push_raw(15, 0, 1'b0, 1'b1, STUCK_LAT);
    repeat (50) drive_bit(1'b1);
    checks++;
    if (stuck_hi !== 1'b1 || sig_lost !== 1'b0 || duty_out !== 4'hf || state_dbg !== STUCK)
      $display("FAIL stuck_state got stk=%0b lost=%0b duty=%0d st=%0d exp 1/0/15/STUCK",
               stuck_hi, sig_lost, duty_out, state_dbg);
    else passes++;
    check_drained("stuck");
    model_meas = 1'b0;
    repeat (5) drive_bit(1'b0);
    checks++;
    if (stuck_hi !== 1'b1) $display("FAIL stuck_fall_hold got=%0b exp=1", stuck_hi);
    else passes++;
    repeat (3) send_period(4, 12);
    check_drained("stuck_recover");
    checks++;
    if (stuck_hi !== 1'b0 || duty_out !== 4'd3 || state_dbg !== MEAS)
      $display("FAIL stuck_recover got stk=%0b duty=%0d st=%0d exp 0/3/MEAS", stuck_hi, duty_out, state_dbg);
    else passes++;
  endtask

  task automatic test_sig_lost();
    int v0;
    do_reset();
    v0 = valid_cnt;
    repeat (3) send_period(10, 6);
    repeat (10) drive_bit(1'b1);
    repeat (40) drive_bit(1'b0);
    checks++;
    if (sig_lost !== 1'b1 || stuck_hi !== 1'b0 || duty_out !== 4'd9 || state_dbg !== STUCK)
      $display("FAIL lost_state got lost=%0b stk=%0b duty=%0d st=%0d exp 1/0/9/STUCK",
               sig_lost, stuck_hi, duty_out, state_dbg);
    else passes++;
    check_drained("lost");
    checks++;
    if (valid_cnt - v0 != 3) $display("FAIL lost_valid_count got=%0d exp=3", valid_cnt - v0);
    else passes++;
  endtask

  task automatic test_glitch();
    do_reset();
    model_en = 1'b0;
    send_period(6, 10);
    push_exp(6, 16, LAT);
`ifndef PWM_CAP_GLITCH_FILTER_EN
    push_exp(6, 10, LAT);
    push_exp(1, 6, LAT);
`else
    push_exp(6, 16, LAT);
`endif
    repeat (6) drive_bit(1'b1);
    repeat (4) drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (5) drive_bit(1'b0);
    send_period(6, 10);
    check_drained("glitch");
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) send_period(6, 10);
    repeat (6) drive_bit(1'b1);
    repeat (3) drive_bit(1'b0);
    check_drained("mid_pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    do_reset();
    repeat (3) send_period(11, 5);
    check_drained("mid_after");
    checks++;
    if (duty_out !== 4'd10 || period_ok !== 1'b1) $display("FAIL mid_after got duty=%0d ok=%0b exp 10/1", duty_out, period_ok);
    else passes++;
  endtask

  initial begin
    rst_n      = 1'b0;
    pwm_in     = 1'b0;
    model_prev = 1'b0;
    model_meas = 1'b0;
    model_en   = 1'b1;
    hi_cnt     = 0;
    len_cnt    = 0;
    rise_cyc   = 0;
    test_reset();
    test_duty5();
    test_duty_patterns();
    test_stuck_hi();
    test_sig_lost();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
